// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 codes, FSM states,
// byte-strobe constants and the store lane/strobe helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } mem_state_t;

  // Size is carried in funct3[1:0]: 00 byte, 01 halfword, anything else word.
  function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return lane;
      2'b01:   return {lane[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lane[0];
      default: return (lane != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return STRB_B << lane;
      2'b01:   return STRB_H << {lane[1], 1'b0};
      default: return STRB_W;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// Load formatter: selects the addressed byte/halfword lane of the read word
// and sign- or zero-extends it according to funct3.
module mem_load_fmt
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_f3,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_data
);

  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;
  logic signed [31:0] w_byte_sx;
  logic signed [31:0] w_half_sx;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_lane)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  assign w_byte_sx = 32'(w_byte);
  assign w_half_sx = 32'(w_half);

  always_comb begin
    o_data = i_rdata;
    case (i_f3)
      F3_B:    o_data = w_byte_sx;
      F3_BU:   o_data = {24'b0, w_byte};
      F3_H:    o_data = w_half_sx;
      F3_HU:   o_data = {16'b0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over valid/ready, stalls
// upstream while outstanding. Optional macro MEM_MISALIGN_TRAP_EN aborts
// misaligned H/W accesses instead of silently aligning them.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_store_data,
  input  logic [2:0]        ex_funct3,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic [4:0]        ex_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       mem_result,
  output logic              mem_reg_write,
  output logic [4:0]        mem_rd,
  output logic              stall_req,
  output logic              mem_err
);

  localparam int CNT_W = 10;

  mem_state_t        r_state, w_next;
  logic [ADDR_W-3:0] r_waddr;
  logic [1:0]        r_lane;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic              r_regw;
  logic              r_we;
  logic              r_abort;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_ldbuf;

  logic              w_op;
  logic              w_misalign;
  logic              w_term;
  logic [1:0]        w_lane;
  logic [31:0]       w_fmt;

  assign w_op   = ex_mem_read | ex_mem_write;
  assign w_lane = align_lane(ex_funct3[1:0], ex_alu_result[1:0]);
  assign w_term = (r_cnt == CNT_W'(TIMEOUT - 1));

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = misaligned(ex_funct3[1:0], ex_alu_result[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  mem_load_fmt u_load_fmt (
    .i_rdata (mem_rdata),
    .i_f3    (r_f3),
    .i_lane  (r_lane),
    .o_data  (w_fmt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_op) w_next = w_misalign ? S_RESP : S_ACCESS;
      S_ACCESS: if (mem_ready || w_term) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Request registers hold the access stable for the whole ACCESS phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waddr <= '0;
      r_lane  <= '0;
      r_wdata <= '0;
      r_wstrb <= STRB_NONE;
      r_f3    <= '0;
      r_rd    <= '0;
      r_regw  <= 1'b0;
      r_we    <= 1'b0;
      r_abort <= 1'b0;
      r_cnt   <= '0;
      r_ldbuf <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_op) begin
          r_waddr <= ex_alu_result[ADDR_W-1:2];
          r_lane  <= w_lane;
          r_wdata <= ex_mem_write ? store_data(ex_funct3[1:0], ex_store_data) : 32'b0;
          r_wstrb <= ex_mem_write ? store_strb(ex_funct3[1:0], w_lane) : STRB_NONE;
          r_f3    <= ex_funct3;
          r_rd    <= ex_rd;
          r_regw  <= ex_reg_write;
          r_we    <= ex_mem_write;
          r_abort <= w_misalign;
          r_cnt   <= '0;
        end
        S_ACCESS: begin
          if (mem_ready)   r_ldbuf <= w_fmt;
          else if (w_term) r_abort <= 1'b1;
          else             r_cnt   <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = {r_waddr, 2'b00};
  assign mem_wdata = r_wdata;

  // While rst is high the stage is a pure pass-through with all controls low.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_wstrb     = STRB_NONE;
    stall_req     = 1'b0;
    mem_reg_write = 1'b0;
    mem_err       = 1'b0;
    mem_result    = ex_alu_result;
    mem_rd        = ex_rd;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          stall_req     = w_op;
          mem_reg_write = ex_reg_write & ~w_op;
        end
        S_ACCESS: begin
          mem_req   = 1'b1;
          mem_we    = r_we;
          mem_wstrb = r_wstrb;
          stall_req = 1'b1;
          mem_rd    = r_rd;
        end
        S_RESP: begin
          mem_result    = r_ldbuf;
          mem_rd        = r_rd;
          mem_reg_write = r_regw & ~r_we & ~r_abort;
          mem_err       = r_abort;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected responses, a
// negedge monitor pops and compares them when a stalled access completes.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_store_data = '0;
  logic [2:0]  ex_funct3 = '0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic        ex_reg_write = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_result;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic        stall_req, mem_err;

  mem_stage #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_result(mem_result), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .stall_req(stall_req), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic        chk_res;
    logic        regw;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall && !stall_req) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL resp_unexpected: got response rd=%0d expected none", mem_rd);
        end else begin
          m_e = q.pop_front();
          if (m_e.chk_res) chk("resp_result", mem_result, m_e.result);
          chk("resp_regw", 32'(mem_reg_write), 32'(m_e.regw));
          chk("resp_rd", 32'(mem_rd), 32'(m_e.rd));
          chk("resp_err", 32'(mem_err), 32'(m_e.err));
        end
      end
      prev_stall = stall_req;
    end
  end

  // k = ACCESS cycle on which ready is given (0 = never).
  task automatic do_mem(input logic rd_i, input logic wr_i, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input logic regw, input int k,
                        input logic [31:0] rdata, input logic [31:0] exp_addr,
                        input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                        input int exp_stall, input int exp_req,
                        input logic [31:0] exp_res, input logic chk_res,
                        input logic exp_regw, input logic exp_err);
    int   stall_n = 0;
    int   req_n = 0;
    int   acc = 0;
    logic done = 1'b0;
    exp_t e;
    @(posedge clk); #1;
    ex_mem_read = rd_i; ex_mem_write = wr_i; ex_funct3 = f3;
    ex_alu_result = addr; ex_store_data = sdata; ex_rd = rd; ex_reg_write = regw;
    mem_ready = 1'b0; mem_rdata = rdata;
    e.result = exp_res; e.chk_res = chk_res; e.regw = exp_regw; e.rd = rd; e.err = exp_err;
    q.push_back(e);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!stall_req) begin done = 1'b1; break; end
      stall_n++;
      if (mem_req) begin
        req_n++;
        chk("acc_addr", mem_addr, exp_addr);
        chk("acc_we", 32'(mem_we), 32'(wr_i));
        chk("acc_wstrb", 32'(mem_wstrb), 32'(exp_strb));
        if (wr_i) chk("acc_wdata", mem_wdata, exp_wdata);
      end else begin
        chk("idle_regw", 32'(mem_reg_write), 32'd0);
      end
      @(posedge clk); #1;
      if (mem_req) begin acc++; mem_ready = (acc == k); end
      else mem_ready = 1'b0;
    end
    if (!done) chk("resp_timeout", 32'd0, 32'd1);
    chk("stall_cycles", stall_n, exp_stall);
    chk("req_cycles", req_n, exp_req);
    @(posedge clk); #1;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("post_err", 32'(mem_err), 32'd0);
    chk("post_stall", 32'(stall_req), 32'd0);
    chk("post_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ex_alu_result = 32'hDEAD; ex_rd = 5'd3; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    #12;
    chk("rst_result", mem_result, 32'hDEAD);
    chk("rst_rd", 32'(mem_rd), 32'd3);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_regw", 32'(mem_reg_write), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    @(negedge clk); rst = 1'b0;

    // ALU pass-through; ready is ignored outside ACCESS
    @(posedge clk); #1;
    ex_alu_result = 32'h1234; ex_rd = 5'd5; ex_reg_write = 1'b1; mem_ready = 1'b1;
    #1;
    chk("alu_result", mem_result, 32'h1234);
    chk("alu_rd", 32'(mem_rd), 32'd5);
    chk("alu_regw", 32'(mem_reg_write), 32'd1);
    chk("alu_stall", 32'(stall_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("alu_req", 32'(mem_req), 32'd0);
      chk("alu_stall_hold", 32'(stall_req), 32'd0);
    end
    @(posedge clk); #1; mem_ready = 1'b0; ex_reg_write = 1'b0;

    // LB / LBU at 0x103, top byte 0x80
    do_mem(1, 0, 3'b000, 32'h103, 0, 5'd7, 1, 1, 32'h80FFFFFF, 32'h100, 0, 4'b0000,
           2, 1, 32'hFFFFFF80, 1, 1, 0);
    do_mem(1, 0, 3'b100, 32'h103, 0, 5'd8, 1, 1, 32'h80FFFFFF, 32'h100, 0, 4'b0000,
           2, 1, 32'h00000080, 1, 1, 0);
    // SH at 0x202, SB at 0x201: no register write even with reg_write set
    do_mem(0, 1, 3'b001, 32'h202, 32'hABCD1234, 5'd9, 1, 1, 0, 32'h200, 32'h12341234,
           4'b1100, 2, 1, 0, 0, 0, 0);
    do_mem(0, 1, 3'b000, 32'h201, 32'h000000A5, 5'd10, 1, 1, 0, 32'h200, 32'hA5A5A5A5,
           4'b0010, 2, 1, 0, 0, 0, 0);
    // LW with ready on the 4th ACCESS cycle
    do_mem(1, 0, 3'b010, 32'h300, 0, 5'd11, 1, 4, 32'hCAFEBABE, 32'h300, 0, 4'b0000,
           5, 4, 32'hCAFEBABE, 1, 1, 0);
    // LH / LHU upper halfword
    do_mem(1, 0, 3'b001, 32'h102, 0, 5'd12, 1, 1, 32'h80017FFF, 32'h100, 0, 4'b0000,
           2, 1, 32'hFFFF8001, 1, 1, 0);
    do_mem(1, 0, 3'b101, 32'h102, 0, 5'd13, 1, 1, 32'h80017FFF, 32'h100, 0, 4'b0000,
           2, 1, 32'h00008001, 1, 1, 0);
    // Timeout: no ready ever, TIMEOUT=8
    do_mem(1, 0, 3'b010, 32'h400, 0, 5'd14, 1, 0, 32'h11111111, 32'h400, 0, 4'b0000,
           9, 8, 0, 0, 0, 1);
    // Misaligned LW at 0x102
`ifdef MEM_MISALIGN_TRAP_EN
    do_mem(1, 0, 3'b010, 32'h102, 0, 5'd15, 1, 1, 32'h13572468, 32'h100, 0, 4'b0000,
           1, 0, 0, 0, 0, 1);
`else
    do_mem(1, 0, 3'b010, 32'h102, 0, 5'd15, 1, 1, 32'h13572468, 32'h100, 0, 4'b0000,
           2, 1, 32'h13572468, 1, 1, 0);
`endif

    // Reset in the middle of ACCESS
    @(posedge clk); #1;
    ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_alu_result = 32'h500; ex_rd = 5'd16;
    ex_reg_write = 1'b1; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_req_before", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_stall", 32'(stall_req), 32'd0);
    chk("midrst_result", mem_result, 32'h500);
    chk("midrst_rd", 32'(mem_rd), 32'd16);
    chk("midrst_addr", mem_addr, 32'd0);
    ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("postrst_stall", 32'(stall_req), 32'd0);
    chk("postrst_req", 32'(mem_req), 32'd0);
    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the EX/MEM register and the MEM/WB register. It issues loads and stores to data memory over a valid/ready handshake and formats byte, halfword and word data. It stalls the upstream pipeline while an access is outstanding. It produces the result, write-enable and destination-register triple that MEM/WB captures.

## Interface
- ADDR_W, 32, byte-address width.
- TIMEOUT, 255, maximum cycles spent in ACCESS before the access is aborted (1..1023).

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ex_alu_result  in  32  ALU result; also the effective byte address for memory ops
- ex_store_data  in  32  store source register value
- ex_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_mem_read  in  1  load instruction present
- ex_mem_write  in  1  store instruction present
- ex_reg_write  in  1  instruction writes rd
- ex_rd  in  5  destination register
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2], 2'b00}
- mem_wdata  out  32  store data, replicated across lanes
- mem_wstrb  out  4  byte-lane enables, 0 for loads
- mem_rdata  in  32  read word, valid with mem_ready
- mem_ready  in  1  memory completes the access this cycle
- mem_result  out  32  to MEM/WB MemResult
- mem_reg_write  out  1  to MEM/WB MemRegWrite
- mem_rd  out  5  to MEM/WB MemRd
- stall_req  out  1  hold IF/ID/EX/EX_MEM registers
- mem_err  out  1  one-cycle pulse: access aborted (timeout or misaligned)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no memory op:
  - mem_result = ex_alu_result, mem_reg_write = ex_reg_write, mem_rd = ex_rd, all combinational.
  - stall_req = 0.
- IDLE with ex_mem_read or ex_mem_write:
  - stall_req = 1 and mem_reg_write = 0.
  - Latches address, write data, strobes, funct3, rd, reg_write and rw into request registers.
  - Next state ACCESS; the timeout counter clears.
  - If both read and write are set, the op is treated as a store.
- ACCESS:
  - mem_req = 1; request outputs are held stable; stall_req = 1.
  - On mem_ready: format mem_rdata into the load buffer and go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 with no ready, go to RESP with the abort flag set.
  - mem_ready and terminal count in the same cycle: ready wins.
- RESP:
  - stall_req = 0; mem_result = load buffer; mem_rd = latched rd.
  - mem_reg_write = latched reg_write AND load AND NOT abort.
  - mem_err = abort flag.
  - Next state IDLE unconditionally. The ex_* inputs still show the stalled instruction and are ignored.
- Store lanes:
  - SB: wstrb = 0001 << addr[1:0], wdata = {4{data[7:0]}}.
  - SH: wstrb = 0011 << {addr[1],0}, wdata = {2{data[15:0]}}.
  - SW: wstrb = 1111.
- Load extract:
  - Byte lane addr[1:0]; halfword lane addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Undefined funct3 values are treated as W.
- mem_ready is ignored in IDLE and RESP.

## Timing
- Non-memory op: 0-cycle combinational pass-through, no stall.
- Memory op with ready in the first ACCESS cycle: 3 cycles (IDLE, ACCESS, RESP); stall_req high for 2 cycles.
- Each additional wait cycle adds 1.
- Timeout: RESP arrives TIMEOUT+1 cycles after IDLE.
- Reset, including mid-access:
  - State goes to IDLE immediately.
  - mem_req, mem_we, mem_wstrb, mem_err, stall_req and mem_reg_write are 0.
  - mem_addr, mem_wdata, request registers and load buffer are 0.
  - While rst is high, mem_result = ex_alu_result and mem_rd = ex_rd.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned access (H with addr[0]=1; W with addr[1:0]≠0) goes IDLE→RESP directly with the abort flag set.
  - No mem_req is issued; mem_err = 1 and mem_reg_write = 0 in RESP.
- Undefined: offending low address bits are cleared (H ignores addr[0], W ignores addr[1:0]) and the access proceeds normally.

## Structure
- Shared package mem_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum mem_state_t.
  - Strobe constants.
- Sub-module mem_load_fmt: purely combinational lane select plus sign/zero extension of the load word.

## Test plan
- ALU op, ex_alu_result=0x1234, rd=5, reg_write=1 -> same-cycle mem_result 0x1234, mem_rd 5, stall_req 0, mem_req never asserted.
- LB at addr 0x103, mem_rdata 0x80FFFFFF, ready on first ACCESS cycle -> mem_addr 0x100, stall 2 cycles, RESP mem_result 0xFFFFFF80; LBU -> 0x00000080.
- SH at 0x202, data 0xABCD1234 -> mem_we 1, wstrb 1100, wdata 0x12341234, mem_reg_write 0 in RESP.
- LW with ready delayed 4 cycles -> mem_req held and address stable throughout, stall_req 5 cycles, RESP returns mem_rdata.
- TIMEOUT=8, ready never asserted -> RESP 9 cycles after IDLE, mem_err pulse 1 cycle, mem_reg_write 0; rst asserted mid-ACCESS -> mem_req 0 immediately, FSM in IDLE.
- LW at 0x102 -> with MEM_MISALIGN_TRAP_EN: no mem_req, mem_err 1; without: mem_addr 0x100, normal load.
